// File: rtl/data_mem_sequencer.sv
// Serialises byte/halfword/word/doubleword accesses onto a byte-wide RAM port,
// big-endian, one byte per clock, with an address range check before any RAM access.
module data_mem_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int MEM_LAST = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        mode,
  input  logic [31:0]       addr,
  input  logic [63:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [63:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               rw_r, rw_s;
  logic [2:0]         n_last_r, n_last_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [63:0]        wdata_r, wdata_s;
  logic [2:0]         idx_r, idx_s;
  logic [2:0]         idx_next_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;
  logic [63:0]        rdata_r, rdata_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
  logic [7:0]         mem_wdata_r, mem_wdata_s;
  logic               mem_we_r, mem_we_s;
  logic [2:0]         req_last_s;
  logic [32:0]        end_s;

  // Byte idx of an access whose last byte index is last; byte 0 is the most significant.
  function automatic logic [7:0] pick_byte(input logic [63:0] data,
                                           input logic [2:0]  last,
                                           input logic [2:0]  idx);
    logic [5:0] pos;
    pos = {last - idx, 3'b000};
    return data[pos +: 8];
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    rw_s        = rw_r;
    n_last_s    = n_last_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    idx_s       = idx_r;
    idx_next_s  = idx_r + 3'd1;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    rdata_s     = rdata_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_we_s    = 1'b0;

    case (mode)
      2'b00:   req_last_s = 3'd0;
      2'b01:   req_last_s = 3'd1;
      2'b10:   req_last_s = 3'd3;
      2'b11:   req_last_s = 3'd7;
      default: req_last_s = 3'd0;
    endcase
    // 33-bit sum so a start address near 2^32 cannot wrap past the check.
    end_s = {1'b0, addr} + {30'd0, req_last_s};

    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (req) begin
          rw_s     = rw;
          n_last_s = req_last_s;
          addr_s   = addr[ADDR_W-1:0];
          wdata_s  = wdata;
          busy_s   = 1'b1;
          if (end_s > 33'(MEM_LAST)) begin
            state_s = ERR;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s    = XFER;
            rdata_s    = 64'd0;
            idx_s      = 3'd0;
            mem_addr_s = addr[ADDR_W-1:0];
            mem_we_s   = rw;
            if (rw) begin
              mem_wdata_s = pick_byte(wdata, req_last_s, 3'd0);
            end else begin
              mem_wdata_s = mem_wdata_r;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (!rw_r) begin
          rdata_s = {rdata_r[55:0], mem_rdata};
        end else begin
          rdata_s = rdata_r;
        end
        if (idx_r == n_last_r) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          idx_s      = idx_next_s;
          mem_addr_s = addr_r + ADDR_W'(idx_next_s);
          mem_we_s   = rw_r;
          if (rw_r) begin
            mem_wdata_s = pick_byte(wdata_r, n_last_r, idx_next_s);
          end else begin
            mem_wdata_s = mem_wdata_r;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      ERR: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access and drops the write strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rw_r        <= 1'b0;
      n_last_r    <= 3'd0;
      addr_r      <= '0;
      wdata_r     <= 64'd0;
      idx_r       <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= 64'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      mem_we_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      rw_r        <= rw_s;
      n_last_r    <= n_last_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      idx_r       <= idx_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      rdata_r     <= rdata_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_we_r    <= mem_we_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Bench for data_mem_sequencer: a transaction-level timeline model predicts every
// output each cycle; directed scenarios pin literal results, then random traffic runs.
module tb_data_mem_sequencer;

  logic        clk, rst_n, req, rw;
  logic [1:0]  mode;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        busy, done, err, mem_we;
  logic [63:0] rdata;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  bit [7:0] ram     [0:255];
  bit [7:0] ref_mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    bit        busy, done, err, we;
    bit [7:0]  addr, wdata;
    bit [63:0] rdata;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  data_mem_sequencer #(.ADDR_W(8), .MEM_LAST(255)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .mode(mode), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Expand one accepted request into the expected outputs of every following cycle.
  task automatic model_accept(input bit w, input bit [1:0] m, input bit [31:0] a, input bit [63:0] d);
    int n;
    exp_t e;
    bit [63:0] full;
    n = 1 << m;
    if ({1'b0, a} + 33'(n) - 33'd1 > 33'd255) begin
      e = cur; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1; e.we = 1'b0;
      q.push_back(e);
    end else begin
      full = 64'd0;
      for (int k = 0; k < n; k++) full = (full << 8) | 64'(ref_mem[a[7:0] + 8'(k)]);
      for (int k = 0; k < n; k++) begin
        e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0; e.we = w;
        e.addr = a[7:0] + 8'(k);
        e.wdata = w ? 8'(d >> (8 * (n - 1 - k))) : cur.wdata;
        e.rdata = (w || k == 0) ? 64'd0 : (full >> (8 * (n - k)));
        q.push_back(e);
      end
      e.done = 1'b1; e.we = 1'b0;
      e.rdata = w ? 64'd0 : full;
      q.push_back(e);
    end
  endtask

  // Reference model: advances one cycle per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur = '0;
    end else begin
      if (cur.we) ref_mem[cur.addr] = cur.wdata;
      if (q.size() == 0 && !cur.busy && req) model_accept(rw, mode, addr, wdata);
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur.busy = 1'b0; cur.done = 1'b0; cur.err = 1'b0; cur.we = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, cur.busy);
    check("done", done, cur.done);
    check("err", err, cur.err);
    check("mem_we", mem_we, cur.we);
    check("mem_addr", mem_addr, cur.addr);
    check("mem_wdata", mem_wdata, cur.wdata);
    check("rdata", rdata, cur.rdata);
  end

  // Called at a negedge while idle; returns at the first idle negedge after done.
  task automatic do_access(input bit w, input bit [1:0] m, input bit [31:0] a, input bit [63:0] d,
                           output int cyc, output bit [63:0] rd, output bit e);
    req = 1'b1; rw = w; mode = m; addr = a; wdata = d;
    cyc = 0; rd = 64'd0; e = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) begin
        cyc = k; rd = rdata; e = err;
        break;
      end
    end
    if (cyc == 0) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c, dn;
  bit [63:0] r;
  bit e;
  bit [7:0] t1b [4];

  initial begin
    t1b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    req = 1'b0; rw = 1'b0; mode = 2'b00; addr = 32'd0; wdata = 64'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_mem_addr", mem_addr, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1
    do_access(1'b1, 2'b10, 32'd8, 64'hAABBCCDD, c, r, e);
    check("t1_latency", c, 5);
    check("t1_err", e, 1'b0);
    for (int j = 0; j < 4; j++) begin
      do_access(1'b0, 2'b00, 32'd8 + 32'(j), 64'($urandom), c, r, e);
      check("t1_read", r, {56'd0, t1b[j]});
      check("t1_read_latency", c, 2);
    end

    // T2
    do_access(1'b1, 2'b01, 32'd3, 64'h1234, c, r, e);
    do_access(1'b0, 2'b10, 32'd2, 64'd0, c, r, e);
    check("t2_rdata", r, 64'h0000_0000_0012_3400);
    check("t2_err", e, 1'b0);

    // T3
    do_access(1'b1, 2'b11, 32'd0, 64'h0102030405060708, c, r, e);
    do_access(1'b0, 2'b11, 32'd0, 64'd0, c, r, e);
    check("t3_rdata", r, 64'h0102030405060708);
    check("t3_latency", c, 9);

    // T4
    do_access(1'b0, 2'b10, 32'd253, 64'd0, c, r, e);
    check("t4a_err", e, 1'b1);
    check("t4a_latency", c, 1);
    check("t4a_rdata", r, 64'h0102030405060708);
    do_access(1'b1, 2'b11, 32'd250, 64'hFFFF_FFFF_FFFF_FFFF, c, r, e);
    check("t4b_err", e, 1'b1);
    check("t4b_latency", c, 1);
    check("t4b_ram250", ram[250], 8'h00);

    // T5: request inputs wiggle while busy
    req = 1'b1; rw = 1'b1; mode = 2'b10; addr = 32'd16; wdata = 64'hDEADBEEF;
    @(posedge clk);
    dn = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (k < 5) begin
        req = 1'($urandom_range(0, 1)); rw = 1'($urandom); mode = 2'b11; addr = 32'd100 + 32'(k);
      end else begin
        req = 1'b0;
      end
    end
    check("t5_done_count", dn, 1);
    check("t5_ram", {ram[16], ram[17], ram[18], ram[19]}, 32'hDEADBEEF);
    check("t5_ram20", ram[20], 8'h00);
    check("t5_ram101", ram[101], 8'h00);

    // T6: reset after the second byte of a doubleword write
    req = 1'b1; rw = 1'b1; mode = 2'b11; addr = 32'd40; wdata = 64'h1122334455667788;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mem_we", mem_we, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_mem_addr", mem_addr, 8'd0);
    check("t6_mem_wdata", mem_wdata, 8'd0);
    check("t6_rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ram40_41", {ram[40], ram[41]}, 16'h1122);
    check("t6_ram42", ram[42], 8'h00);
    check("t6_ram47", ram[47], 8'h00);

    // Random traffic, including held req for back-to-back accepts
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) != 0);
      rw = 1'($urandom);
      mode = 2'($urandom);
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1, 2:    addr = 32'd248 + 32'($urandom_range(0, 7));
        default: addr = 32'($urandom_range(0, 255));
      endcase
      wdata = {$urandom, $urandom};
    end
    req = 1'b0;
    repeat (20) @(negedge clk);
    for (int a = 0; a < 256; a++) check("ram_contents", ram[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
